key_counter: RTL and testbench
==============================

Name: key_counter

Overview:
- Upstream input stage for the binary-to-BCD / seven-segment display path.
- Debounces three active-low push-buttons (up, down, load) and turns each debounced press into a single event.
- Maintains a WIDTH-bit binary count. `count` drives the BCD converter directly, replacing raw switch input, so the displayed value steps once per physical press.

Parameters:
- WIDTH, 4, bit width of count and load_value.
- MAX_VALUE, 15, highest legal count value; must be ≤ 2^WIDTH−1.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits.

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst  input  1  synchronous, active-high reset.
- key_up_n  input  1  raw asynchronous button, active-low, increment.
- key_down_n  input  1  raw asynchronous button, active-low, decrement.
- key_load_n  input  1  raw asynchronous button, active-low, load.
- load_value  input  WIDTH  value loaded on a load press (board switches); sampled on the event cycle.
- count  output  WIDTH  current binary count, registered.
- changed  output  1  one-cycle pulse, high in the cycle after count takes a new value.

Behaviour:
- Reset, synchronous, highest priority:
  - count = 0, changed = 0.
  - All synchronizer flops = 1; all debounced states = 1 (released).
  - All debounce counters = 0.
  - Reset mid-debounce discards partial progress. No event fires from pre-reset activity.
- Synchronizer: each key passes through 2 flops before any other logic.
- Debounce, per key, independent:
  - Counter increments each cycle the synchronized level differs from the debounced state.
  - Counter clears to 0 on any cycle where they match.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced state takes the new level and the counter clears.
- Events:
  - A press event is a debounced 1→0 transition only.
  - Releases are debounced but produce no event.
  - Holding a key produces exactly one event.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce nothing.
- Latency: number edges from the first edge that samples the key low as edge 1, with the key held low throughout. The debounced state flips at edge DEBOUNCE_CYCLES+2. count updates at edge DEBOUNCE_CYCLES+3. changed is high for the following cycle only.
- Event resolution, per cycle:
  - load event: count ← min(load_value, MAX_VALUE); overrides any up/down event in the same cycle.
  - up and down events in the same cycle, no load: no change, changed stays 0.
  - up only:
    - count < MAX_VALUE: count+1.
    - count = MAX_VALUE: 0 if WRAP=1; otherwise hold.
  - down only:
    - count > 0: count−1.
    - count = 0: MAX_VALUE if WRAP=1; otherwise hold.
- changed rules:
  - Asserts only when count's new value differs from its old value.
  - A saturated hold does not assert it.
  - A load of the current value does not assert it.
- Arithmetic: unsigned, WIDTH bits. count never exceeds MAX_VALUE.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, MAX_VALUE=15):
- Reset then idle, keys=1 for 20 cycles -> count=0, changed never high. Assert rst for 1 cycle mid-run -> count=0 on the next edge.
- key_up_n low for 10 cycles starting at edge 1 -> count 0→1 exactly at edge 7, changed high for one cycle. Key stays low for another 50 cycles -> no further change.
- key_up_n low pulses of 3 cycles, repeated -> count unchanged. Bounce pattern 0,1,0,0,0,0,0 -> single increment.
- WRAP=1: 15 up presses from 0 -> count=15, 16th -> 0; 1 down press from 0 -> 15. Rerun with WRAP=0 -> 16th up holds 15 with no changed pulse; down at 0 holds 0.
- load_value=9, key_load_n pressed -> count=9, changed pulses. load_value=15 with count=15 -> no changed. MAX_VALUE=9 build, load_value=12 -> count=9.
- Up and down press debounced in the same cycle -> count unchanged, no changed. Up, down and load debounced in the same cycle with load_value=3 -> count=3.

Source files
------------

// File: rtl/key_counter_if.sv
// Bundles the push-button inputs, switch value and count outputs of key_counter.
// master drives the keys and switches; slave is the counter itself.
interface key_counter_if #(
    parameter int WIDTH = 4
);
    logic             key_up_n;
    logic             key_down_n;
    logic             key_load_n;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             changed;

    modport master (
        output key_up_n,
        output key_down_n,
        output key_load_n,
        output load_value,
        input  count,
        input  changed
    );

    modport slave (
        input  key_up_n,
        input  key_down_n,
        input  key_load_n,
        input  load_value,
        output count,
        output changed
    );
endinterface

// File: rtl/key_counter.sv
// Debounced up/down/load push-button counter feeding the BCD display path.
// Each key: 2-flop synchronizer, stable-run debouncer, press-edge event; events resolve into count.
module key_counter #(
    parameter int WIDTH           = 4,
    parameter int MAX_VALUE       = 15,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 1
) (
    input  logic           clk,
    input  logic           rst,
    key_counter_if.slave   bus
);
    localparam int NKEYS    = 3;
    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_LOAD = 2;
    localparam int CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);

    logic [NKEYS-1:0] key_raw_n;
    logic [NKEYS-1:0] key_press;

    assign key_raw_n = {bus.key_load_n, bus.key_down_n, bus.key_up_n};

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            logic             meta_q,  meta_d;
            logic             sync_q,  sync_d;
            logic             db_q,    db_d;
            logic             press_q, press_d;
            logic [CNT_W-1:0] run_q,   run_d;

            // The run counter only ever reaches DEBOUNCE_CYCLES-1; the next
            // differing cycle is the accepting one and clears it again.
            always_comb begin
                meta_d  = key_raw_n[gi];
                sync_d  = meta_q;
                db_d    = db_q;
                run_d   = '0;
                press_d = 1'b0;
                if (sync_q != db_q) begin
                    if (run_q == CNT_LAST) begin
                        db_d    = sync_q;
                        press_d = ~sync_q;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q  <= 1'b1;
                    sync_q  <= 1'b1;
                    db_q    <= 1'b1;
                    run_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    meta_q  <= meta_d;
                    sync_q  <= sync_d;
                    db_q    <= db_d;
                    run_q   <= run_d;
                    press_q <= press_d;
                end
            end

            assign key_press[gi] = press_q;
        end
    endgenerate

    logic [WIDTH-1:0] count_q,   count_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;

    always_comb begin
        count_d = count_q;
        if (key_press[KEY_LOAD]) begin
            count_d = load_clamped;
        end else if (key_press[KEY_UP] && !key_press[KEY_DOWN]) begin
            if (count_q < MAX_W) begin
                count_d = count_q + 1'b1;
            end else if (WRAP != 0) begin
                count_d = '0;
            end
        end else if (key_press[KEY_DOWN] && !key_press[KEY_UP]) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (WRAP != 0) begin
                count_d = MAX_W;
            end
        end
        // Holds at a limit and reloads of the same value leave changed low.
        changed_d = (count_d != count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            changed_q <= changed_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_key_counter.sv
// Bench for key_counter: three builds (wrap/15, saturate/15, wrap/9) share one stimulus
// and are compared every cycle against a history-window reference model.
module tb_key_counter;
    localparam int D = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_n, dn_n, ld_n;
    logic [W-1:0] lv;

    always #5 clk = ~clk;

    key_counter_if #(.WIDTH(W)) if_a ();
    key_counter_if #(.WIDTH(W)) if_b ();
    key_counter_if #(.WIDTH(W)) if_c ();

    assign if_a.key_up_n = up_n;  assign if_a.key_down_n = dn_n;
    assign if_a.key_load_n = ld_n; assign if_a.load_value = lv;
    assign if_b.key_up_n = up_n;  assign if_b.key_down_n = dn_n;
    assign if_b.key_load_n = ld_n; assign if_b.load_value = lv;
    assign if_c.key_up_n = up_n;  assign if_c.key_down_n = dn_n;
    assign if_c.key_load_n = ld_n; assign if_c.load_value = lv;

    key_counter #(.WIDTH(W), .MAX_VALUE(15), .DEBOUNCE_CYCLES(D), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    key_counter #(.WIDTH(W), .MAX_VALUE(15), .DEBOUNCE_CYCLES(D), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    key_counter #(.WIDTH(W), .MAX_VALUE(9), .DEBOUNCE_CYCLES(D), .WRAP(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: per build count/changed, per key a history of sampled raw levels.
    int  maxv[3]  = '{15, 15, 9};
    bit  wrapv[3] = '{1'b1, 1'b0, 1'b1};
    int  m_cnt[3];
    bit  m_chg[3];
    bit  hist[3][$];
    bit  db[3];
    bit  ev[3];

    function automatic int resolve(int c, bit up, bit dn, bit ld, int lval, int mx, bit wr);
        if (ld) return (lval > mx) ? mx : lval;
        if (up && dn) return c;
        if (up) return (c < mx) ? c + 1 : (wr ? 0 : c);
        if (dn) return (c > 0) ? c - 1 : (wr ? mx : c);
        return c;
    endfunction

    // A key's accepted level flips once the last D synchronized samples (raw levels seen
    // two edges earlier) all disagree with it; a flip to 0 is a press, acted on one edge later.
    task automatic model_edge(input bit raw[3], input bit r, input int lval);
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_chg[i] = 1'b0;
                db[i]    = 1'b1;
                ev[i]    = 1'b0;
                hist[i].delete();
                for (int j = 0; j < D + 2; j++) hist[i].push_back(1'b1);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int nv;
                nv = resolve(m_cnt[i], ev[0], ev[1], ev[2], lval, maxv[i], wrapv[i]);
                m_chg[i] = (nv != m_cnt[i]);
                m_cnt[i] = nv;
            end
            for (int k = 0; k < 3; k++) begin
                int  n;
                bit  all_diff;
                hist[k].push_back(raw[k]);
                n = hist[k].size();
                all_diff = 1'b1;
                for (int j = n - 2 - D; j <= n - 3; j++)
                    if (hist[k][j] == db[k]) all_diff = 1'b0;
                ev[k] = 1'b0;
                if (all_diff) begin
                    db[k] = ~db[k];
                    ev[k] = (db[k] == 1'b0);
                end
                if (n > 64) void'(hist[k].pop_front());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        bit raw[3];
        bit r;
        int lval;
        raw  = '{up_n, dn_n, ld_n};
        r    = rst;
        lval = int'(lv);
        @(posedge clk);
        model_edge(raw, r, lval);
        #1;
        chk("count_a",   32'(if_a.count),   32'(m_cnt[0]));
        chk("changed_a", 32'(if_a.changed), 32'(m_chg[0]));
        chk("count_b",   32'(if_b.count),   32'(m_cnt[1]));
        chk("changed_b", 32'(if_b.changed), 32'(m_chg[1]));
        chk("count_c",   32'(if_c.count),   32'(m_cnt[2]));
        chk("changed_c", 32'(if_c.changed), 32'(m_chg[2]));
        $display("cyc rst=%0b keys(u,d,l)=%0b%0b%0b lv=%0d count a/b/c=%0d/%0d/%0d changed=%0b%0b%0b",
                 r, raw[0], raw[1], raw[2], lval, if_a.count, if_b.count, if_c.count,
                 if_a.changed, if_b.changed, if_c.changed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // mask bit0=up, bit1=down, bit2=load
    task automatic press(input bit [2:0] mask, input int hold, input int rel);
        up_n = ~mask[0];
        dn_n = ~mask[1];
        ld_n = ~mask[2];
        idle(hold);
        up_n = 1'b1;
        dn_n = 1'b1;
        ld_n = 1'b1;
        idle(rel);
    endtask

    initial begin
        rst  = 1'b1;
        up_n = 1'b1; dn_n = 1'b1; ld_n = 1'b1;
        lv   = '0;
        idle(3);
        rst = 1'b0;

        // Idle, then a one-cycle reset mid-run.
        idle(10);
        chk("idle_count", 32'(if_a.count), 32'd0);
        press(3'b001, D + 4, D + 4);
        do_reset();
        chk("midrun_reset", 32'(if_a.count), 32'd0);
        idle(10);

        // Latency: the next edge is edge 1 sampling the key low.
        up_n = 1'b0;
        idle(6);
        chk("lat_e6_count", 32'(if_a.count), 32'd0);
        step();
        chk("lat_e7_count", 32'(if_a.count), 32'd1);
        chk("lat_e7_changed", 32'(if_a.changed), 32'd1);
        step();
        chk("lat_e8_changed", 32'(if_a.changed), 32'd0);
        idle(50);
        chk("hold_once", 32'(if_a.count), 32'd1);
        up_n = 1'b1;
        idle(D + 4);

        // Short glitches, then a bounce that still yields one increment.
        for (int i = 0; i < 5; i++) press(3'b001, D - 1, 2);
        idle(D + 4);
        chk("glitch_count", 32'(if_a.count), 32'd1);
        up_n = 1'b0; step(); up_n = 1'b1; step(); up_n = 1'b0; idle(5 + D);
        up_n = 1'b1; idle(D + 4);
        chk("bounce_count", 32'(if_a.count), 32'd2);

        // Limits: 15 ups from 0, a 16th, and a down at 0.
        do_reset();
        for (int i = 0; i < 15; i++) press(3'b001, D + 3, D + 3);
        chk("up15_a", 32'(if_a.count), 32'd15);
        chk("up15_b", 32'(if_b.count), 32'd15);
        press(3'b001, D + 3, D + 3);
        chk("up16_wrap_a", 32'(if_a.count), 32'd0);
        chk("up16_sat_b", 32'(if_b.count), 32'd15);
        do_reset();
        press(3'b010, D + 3, D + 3);
        chk("down0_wrap_a", 32'(if_a.count), 32'd15);
        chk("down0_sat_b", 32'(if_b.count), 32'd0);
        chk("down0_wrap_c", 32'(if_c.count), 32'd9);

        // Loads: plain, same-value, clamped.
        lv = 4'd9;
        press(3'b100, D + 3, D + 3);
        chk("load9_a", 32'(if_a.count), 32'd9);
        lv = 4'd15;
        press(3'b100, D + 3, D + 3);
        press(3'b100, D + 3, D + 3);
        chk("load15_b", 32'(if_b.count), 32'd15);
        lv = 4'd12;
        press(3'b100, D + 3, D + 3);
        chk("load12_clamp_c", 32'(if_c.count), 32'd9);

        // Simultaneous events.
        press(3'b011, D + 3, D + 3);
        chk("updown_a", 32'(if_a.count), 32'd12);
        lv = 4'd3;
        press(3'b111, D + 3, D + 3);
        chk("all_load_a", 32'(if_a.count), 32'd3);
        chk("all_load_c", 32'(if_c.count), 32'd3);

        // Randomized key levels, switch values and occasional resets.
        for (int i = 0; i < 300; i++) begin
            up_n = 1'($urandom_range(0, 1));
            dn_n = 1'($urandom_range(0, 1));
            ld_n = ($urandom_range(0, 3) != 0);
            lv   = W'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 59) == 0);
            idle(int'($urandom_range(1, 2 * D + 2)));
            rst  = 1'b0;
        end
        up_n = 1'b1; dn_n = 1'b1; ld_n = 1'b1;
        idle(D + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
